xor_gate_sweep_ctrl: RTL and testbench

//  Self-test sequencer for the 4-input XOR gate block (inputs a,b,c,d; outputs e,f,g).
//  - Drives all 16 input combinations into the gate and waits a settle window.
//  - Samples e/f/g, checks them against expected parity, and reports pass/fail and error statistics.
//  - Sits beside the gate as its only driver; replaces free-running toggle stimulus with a clocked sweep.

---
 rtl/xor_gate_sweep_ctrl.sv | 155 +++++++++++++++
 tb/tb_xor_gate_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_gate_sweep_ctrl.sv
// Clocked self-test sequencer for the 4-input XOR gate block: sweeps all 16 vectors,
// checks e/f/g against expected parity and reports pass/fail plus error statistics.
module xor_gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             vec_a,
  output logic             vec_b,
  output logic             vec_c,
  output logic             vec_d,
  input  logic             gate_e,
  input  logic             gate_f,
  input  logic             gate_g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_vec
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CW-1:0]    SettleLoad = CW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    PassLast   = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ErrMax     = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic [PW-1:0]    r_pass_cnt, w_pass_cnt_d;
  logic [3:0]       r_vec, w_vec_d;
  logic             r_busy, r_done, r_pass, w_pass_d;
  logic [ERR_W-1:0] r_err, w_err_d;
  logic             r_ffv, w_ffv_d;
  logic [3:0]       r_ffvec, w_ffvec_d;

  logic [2:0]       w_expect;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_inc;

  assign w_expect   = {r_vec[3] ^ r_vec[2], r_vec[1] ^ r_vec[0], ^r_vec};
  assign w_mismatch = ({gate_e, gate_f, gate_g} != w_expect);
  assign w_err_inc  = (r_err == ErrMax) ? r_err : r_err + 1'b1;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_pass_cnt_d = r_pass_cnt;
    w_vec_d      = r_vec;
    w_pass_d     = r_pass;
    w_err_d      = r_err;
    w_ffv_d      = r_ffv;
    w_ffvec_d    = r_ffvec;
    unique case (r_state)
      StIdle: begin
        if (start && !abort) begin
          w_state_d    = StSettle;
          w_cnt_d      = SettleLoad;
          w_pass_cnt_d = '0;
          w_vec_d      = 4'b0000;
          w_pass_d     = 1'b0;
          w_err_d      = '0;
          w_ffv_d      = 1'b0;
          w_ffvec_d    = 4'b0000;
        end
      end
      StSettle: begin
        if (abort) begin
          w_state_d = StIdle;
          w_vec_d   = 4'b0000;
        end else if (r_cnt == '0) begin
          w_state_d = StSample;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StSample: begin
        // The compare is applied even when abort lands on this cycle.
        if (w_mismatch) begin
          w_err_d = w_err_inc;
          if (!r_ffv) begin
            w_ffv_d   = 1'b1;
            w_ffvec_d = r_vec;
          end
        end
        if (abort) begin
          w_state_d = StIdle;
          w_vec_d   = 4'b0000;
        end else if (r_vec != 4'hf) begin
          w_state_d = StSettle;
          w_cnt_d   = SettleLoad;
          w_vec_d   = r_vec + 4'h1;
        end else if (r_pass_cnt != PassLast) begin
          w_state_d    = StSettle;
          w_cnt_d      = SettleLoad;
          w_vec_d      = 4'h0;
          w_pass_cnt_d = r_pass_cnt + 1'b1;
        end else begin
          w_state_d = StDone;
          w_pass_d  = (r_err == '0) && !w_mismatch;
        end
      end
      StDone: begin
        w_state_d = StIdle;
        if (abort) w_vec_d = 4'b0000;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_pass_cnt <= '0;
      r_vec      <= 4'b0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_ffv      <= 1'b0;
      r_ffvec    <= 4'b0000;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_pass_cnt <= w_pass_cnt_d;
      r_vec      <= w_vec_d;
      r_busy     <= (w_state_d == StSettle) || (w_state_d == StSample);
      r_done     <= (w_state_d == StDone);
      r_pass     <= w_pass_d;
      r_err      <= w_err_d;
      r_ffv      <= w_ffv_d;
      r_ffvec    <= w_ffvec_d;
    end
  end

  assign vec_a            = r_vec[3];
  assign vec_b            = r_vec[2];
  assign vec_c            = r_vec[1];
  assign vec_d            = r_vec[0];
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_xor_gate_sweep_ctrl.sv
// Directed bench for xor_gate_sweep_ctrl: ideal and faulty gate models on three
// parameterisations (PASSES=1, PASSES=3, PASSES=3 with a 4-bit error counter).
module tb_xor_gate_sweep_ctrl;

  logic clk;
  logic rst_n;
  logic start0, abort0, start12, abort12;
  int   mode0, mode12;  // 0 ideal, 1 g stuck-at-0, 2 f stuck-at-1

  int n_checks;
  int n_fail;

  function automatic logic [2:0] gate_model(input logic [3:0] v, input int mode);
    logic [2:0] r;
    r = {v[3] ^ v[2], v[1] ^ v[0], v[3] ^ v[2] ^ v[1] ^ v[0]};
    if (mode == 1) r[0] = 1'b0;
    if (mode == 2) r[1] = 1'b1;
    return r;
  endfunction

  // Instance 0: SETTLE=4, PASSES=1, ERR_W=6
  logic a0, b0, c0, d0, busy0, done0, pass0, ffv0;
  logic [5:0] err0;
  logic [3:0] ffvec0, v0;
  logic [2:0] gm0;
  assign v0  = {a0, b0, c0, d0};
  assign gm0 = gate_model(v0, mode0);

  xor_gate_sweep_ctrl #(.SETTLE_CYCLES(4), .PASSES(1), .ERR_W(6)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .vec_a(a0), .vec_b(b0), .vec_c(c0), .vec_d(d0),
    .gate_e(gm0[2]), .gate_f(gm0[1]), .gate_g(gm0[0]),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
  );

  // Instance 1: PASSES=3, ERR_W=6
  logic a1, b1, c1, d1, busy1, done1, pass1, ffv1;
  logic [5:0] err1;
  logic [3:0] ffvec1, v1;
  logic [2:0] gm1;
  assign v1  = {a1, b1, c1, d1};
  assign gm1 = gate_model(v1, mode12);

  xor_gate_sweep_ctrl #(.SETTLE_CYCLES(4), .PASSES(3), .ERR_W(6)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start12), .abort(abort12),
    .vec_a(a1), .vec_b(b1), .vec_c(c1), .vec_d(d1),
    .gate_e(gm1[2]), .gate_f(gm1[1]), .gate_g(gm1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  // Instance 2: PASSES=3, ERR_W=4 (saturates at 15)
  logic a2, b2, c2, d2, busy2, done2, pass2, ffv2;
  logic [3:0] err2;
  logic [3:0] ffvec2, v2;
  logic [2:0] gm2;
  assign v2  = {a2, b2, c2, d2};
  assign gm2 = gate_model(v2, mode12);

  xor_gate_sweep_ctrl #(.SETTLE_CYCLES(4), .PASSES(3), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start12), .abort(abort12),
    .vec_a(a2), .vec_b(b2), .vec_c(c2), .vec_d(d2),
    .gate_e(gm2[2]), .gate_f(gm2[1]), .gate_g(gm2[0]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Start edge becomes cycle 0; returns just after that edge.
  task automatic pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  // Waits for done on instance 0, counting cycles from base; also tallies vector
  // trajectory deviations from the expected idx = cycle/5 order.
  task automatic wait_done0(input int base, output int cyc, output int vec_bad);
    cyc     = -1;
    vec_bad = 0;
    for (int k = base; k < base + 400; k++) begin
      @(negedge clk);
      if (k < 80 && (v0 !== 4'(k / 5) || busy0 !== 1'b1)) vec_bad++;
      if (done0) begin
        cyc = k;
        break;
      end
    end
  endtask

  int cyc, bad, ca, cb, npulse;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start12 = 1'b0; abort12 = 1'b0;
    mode0 = 0; mode12 = 0;
    #12;
    check("reset_outputs", {v0, busy0, done0, pass0, err0, ffv0, ffvec0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ideal gate
    pulse_start0();
    wait_done0(0, cyc, bad);
    check("t1_done_cycle", cyc, 80);
    check("t1_vec_sequence", bad, 0);
    check("t1_pass", pass0, 1);
    check("t1_err", err0, 0);
    check("t1_ffv", ffv0, 0);

    // 2: gate_g stuck-at-0
    mode0 = 1;
    pulse_start0();
    wait_done0(0, cyc, bad);
    check("t2_done_cycle", cyc, 80);
    check("t2_err", err0, 8);
    check("t2_ffv", ffv0, 1);
    check("t2_ffvec", ffvec0, 4'b0001);
    check("t2_pass", pass0, 0);

    // 3: PASSES=3, gate_f stuck-at-1, both counter widths
    mode12 = 2;
    @(negedge clk);
    start12 = 1'b1;
    @(posedge clk);
    #1 start12 = 1'b0;
    ca = -1; cb = -1;
    for (int k = 0; k < 400 && (ca < 0 || cb < 0); k++) begin
      @(negedge clk);
      if (done1 && ca < 0) ca = k;
      if (done2 && cb < 0) cb = k;
    end
    check("t3_done_cycle_w6", ca, 240);
    check("t3_done_cycle_w4", cb, 240);
    check("t3_err_w6", err1, 24);
    check("t3_err_w4_sat", err2, 15);
    check("t3_ffvec_w6", ffvec1, 4'b0000);
    check("t3_ffvec_w4", ffvec2, 4'b0000);
    check("t3_ffv_w6", ffv1, 1);
    check("t3_pass_w6", pass1, 0);

    // 4: abort in SETTLE of idx 5, then a clean restart
    mode0 = 1;
    pulse_start0();
    repeat (27) @(negedge clk);
    check("t4_at_idx5", {busy0, v0}, {1'b1, 4'd5});
    abort0 = 1'b1;
    @(posedge clk);
    #1 abort0 = 1'b0;
    @(negedge clk);
    check("t4_busy_vec", {busy0, v0}, 5'b0);
    check("t4_done_pass", {done0, pass0}, 2'b00);
    check("t4_partial_err", err0, 3);
    check("t4_partial_ff", {ffv0, ffvec0}, {1'b1, 4'b0001});
    npulse = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done0 || busy0) npulse++;
    end
    check("t4_no_done_after_abort", npulse, 0);
    mode0 = 0;
    pulse_start0();
    wait_done0(0, cyc, bad);
    check("t4_rerun_cycle", cyc, 80);
    check("t4_rerun_vecs", bad, 0);
    check("t4_rerun_result", {pass0, err0, ffv0, ffvec0}, {1'b1, 6'd0, 1'b0, 4'b0});

    // 5: start mid-sweep and in the DONE cycle are ignored
    pulse_start0();
    repeat (40) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done0(40, cyc, bad);
    check("t5_done_cycle", cyc, 80);
    check("t5_vecs", bad, 0);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    @(negedge clk);
    check("t5_idle_after_done", {busy0, done0}, 2'b00);
    @(negedge clk);
    check("t5_no_restart", busy0, 0);

    // 6: asynchronous reset at idx 9 between edges
    mode0 = 1;
    pulse_start0();
    repeat (47) @(negedge clk);
    check("t6_at_idx9", v0, 9);
    check("t6_err_before_rst", err0, 5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_clear", {v0, busy0, done0, pass0, err0, ffv0, ffvec0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mode0 = 0;
    pulse_start0();
    wait_done0(0, cyc, bad);
    check("t6_after_rst_cycle", cyc, 80);
    check("t6_after_rst_vecs", bad, 0);
    check("t6_after_rst_pass", {pass0, err0}, {1'b1, 6'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
